mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one memory port between two requesters: master 0 (IFU fetch) and master 1 (LSU load/store).
- Sits between the fetch/load-store units and the single SRAM/bus bridge of the core.
- Uses round-robin arbitration and allows one outstanding transaction at a time, with a response-timeout guard.
- All request and response channels use valid/ready handshakes; a transfer occurs on a cycle where both are 1.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. The write mask is DATA_W/8 bits.
- TIMEOUT, 255, maximum cycles spent waiting for a response. 0 disables the timeout.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mN_req_valid  in  1  request valid from master N (N=0,1).
- mN_req_ready  out  1  request accepted by the arbiter (N=0,1).
- mN_req_addr  in  ADDR_W  request address (N=0,1).
- mN_req_wen  in  1  1 = write, 0 = read (N=0,1).
- mN_req_wdata  in  DATA_W  write data (N=0,1).
- mN_req_wmask  in  DATA_W/8  byte write enables (N=0,1).
- mN_resp_valid  out  1  response valid to master N (N=0,1).
- mN_resp_ready  in  1  master N can accept a response (N=0,1).
- mN_resp_rdata  out  DATA_W  read data; the same value is driven to both masters (N=0,1).
- mN_resp_err  out  1  error flag: downstream error or timeout (N=0,1).
- mem_req_valid  out  1  downstream request valid.
- mem_req_ready  in  1  downstream request ready.
- mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wmask  out  ADDR_W / 1 / DATA_W / DATA_W/8  fields of the granted master's request.
- mem_resp_valid  in  1  downstream response valid.
- mem_resp_ready  out  1  downstream response ready.
- mem_resp_rdata  in  DATA_W  downstream read data.
- mem_resp_err  in  1  downstream error.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- State machine states: IDLE, REQ, RESP, ERR. The granted master is held in register `owner`; the last-served master is held in `last`.
- Reset state: IDLE, owner=0, last=1 (so master 0 wins the first tie), timeout counter=0.
- Outputs immediately after reset: all mN_req_ready=0, all mN_resp_valid=0, mN_resp_err=0, mem_req_valid=0, mem_resp_ready=1, busy=0.
- IDLE, grant selection:
  - Exactly one mN_req_valid set: owner becomes N.
  - Both set: owner becomes the master that is not `last`.
  - Neither set: stay in IDLE.
  - On a grant, go to REQ next cycle. Arbitration costs exactly 1 cycle.
  - No mN_req_ready is asserted while in IDLE.
- REQ, forwarding the request:
  - mem_req_valid=1.
  - mem_req_* fields are combinationally muxed from the owner's inputs.
  - m[owner]_req_ready = mem_req_ready; the other master's req_ready = 0.
  - On the mem handshake, go to RESP and clear the timeout counter.
  - The owner must hold its request stable until accepted. The arbiter never drops a grant while in REQ.
- RESP, routing the response:
  - m[owner]_resp_valid = mem_resp_valid.
  - mN_resp_rdata = mem_resp_rdata; m[owner]_resp_err = mem_resp_err.
  - mem_resp_ready = m[owner]_resp_ready.
  - On the handshake, set last=owner and go to IDLE.
  - The timeout counter increments on each RESP cycle without mem_resp_valid. If TIMEOUT!=0 and the counter reaches TIMEOUT, go to ERR.
- ERR, reporting a timeout:
  - m[owner]_resp_valid=1, resp_err=1, rdata=0.
  - mem_resp_ready=1, so a late downstream response is discarded.
  - On m[owner]_resp_ready, set last=owner and go to IDLE.
- Stale responses: outside RESP, mem_resp_ready=1 and mem_resp_valid is ignored.
- The non-owner master always sees req_ready=0 and resp_valid=0.
- Throughput: at best 1 transaction per 3 cycles (IDLE, REQ, RESP) with zero-wait memory. There is no back-to-back bypass.
- A request held pending is never lost. A losing master is served immediately after the current owner, so there is no starvation.
- Reset asserted mid-transaction returns the block to the reset state next cycle. The outstanding transaction is abandoned; downstream shares the same reset.
- The timeout counter width is $clog2(TIMEOUT+1) and it saturates at TIMEOUT.

Test Plan:
- Single read, master 0 only:
  - Stimulus: m0 read at addr 0x80000000; mem_req_ready=1 immediately; mem_resp_valid one cycle later with rdata 0xDEADBEEF.
  - Required: mem_req_valid high in cycle 1 after m0_req_valid; m0_resp_valid with 0xDEADBEEF, err=0; busy back to 0 after the response.
- Simultaneous requests, repeated:
  - Stimulus: m0 and m1 both valid continuously for 4 transactions.
  - Required: grant order 0,1,0,1; mem_req_addr alternates between the two masters' addresses.
- Write pass-through:
  - Stimulus: m1 write, addr 0x80001000, wdata 0x12345678, wmask 0b0011, mem_req_ready held low for 3 cycles.
  - Required: fields stable on mem_req_*; m1_req_ready pulses only in the accept cycle; m0 sees no ready or valid.
- Response backpressure:
  - Stimulus: m0_resp_ready=0 for 2 cycles while mem_resp_valid=1.
  - Required: mem_resp_ready=0 during those cycles; the data is delivered once when ready rises.
- Timeout:
  - Stimulus: TIMEOUT=4; downstream never responds.
  - Required: after 4 RESP cycles, m0_resp_valid=1, err=1, rdata=0; a later mem_resp_valid is sunk while in IDLE.
- Reset mid-transaction:
  - Stimulus: assert reset while in RESP.
  - Required: next cycle all valid/ready outputs at reset values and busy=0; the first post-reset tie grants master 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (master 0) and LSU (master 1).
// One transaction in flight at a time; a stalled response is turned into an error after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ADDR_W-1:0]   m0_req_addr,
  input  logic                m0_req_wen,
  input  logic [DATA_W-1:0]   m0_req_wdata,
  input  logic [DATA_W/8-1:0] m0_req_wmask,
  output logic                m0_resp_valid,
  input  logic                m0_resp_ready,
  output logic [DATA_W-1:0]   m0_resp_rdata,
  output logic                m0_resp_err,
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ADDR_W-1:0]   m1_req_addr,
  input  logic                m1_req_wen,
  input  logic [DATA_W-1:0]   m1_req_wdata,
  input  logic [DATA_W/8-1:0] m1_req_wmask,
  output logic                m1_resp_valid,
  input  logic                m1_resp_ready,
  output logic [DATA_W-1:0]   m1_resp_rdata,
  output logic                m1_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  input  logic                mem_resp_err,
  output logic                busy
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             owner_resp_ready;
  logic             resp_valid;
  logic             resp_err;

  assign owner_resp_ready = owner_q ? m1_resp_ready : m0_resp_ready;
  assign cnt_inc          = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // On a tie the master that was not served last wins.
        if (m0_req_valid || m1_req_valid) begin
          owner_d = (m0_req_valid && m1_req_valid) ? ~last_q : m1_req_valid;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        if (mem_resp_valid) begin
          if (owner_resp_ready) begin
            last_d  = owner_q;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
          if (TIMEOUT != 0 && cnt_inc == TIMEOUT_C) begin
            state_d = ERR;
          end
        end
      end
      ERR: begin
        if (owner_resp_ready) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_addr  = owner_q ? m1_req_addr  : m0_req_addr;
  assign mem_req_wen   = owner_q ? m1_req_wen   : m0_req_wen;
  assign mem_req_wdata = owner_q ? m1_req_wdata : m0_req_wdata;
  assign mem_req_wmask = owner_q ? m1_req_wmask : m0_req_wmask;

  // Outside RESP the downstream response channel is always sunk, so stale responses vanish.
  always_comb begin
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b1;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    m0_resp_rdata  = mem_resp_rdata;
    case (state_q)
      REQ:  mem_req_valid = 1'b1;
      RESP: begin
        mem_resp_ready = owner_resp_ready;
        resp_valid     = mem_resp_valid;
        resp_err       = mem_resp_err;
      end
      ERR: begin
        resp_valid    = 1'b1;
        resp_err      = 1'b1;
        m0_resp_rdata = '0;
      end
      default: ;
    endcase
  end

  assign m1_resp_rdata = m0_resp_rdata;
  assign m0_req_ready  = mem_req_valid && !owner_q && mem_req_ready;
  assign m1_req_ready  = mem_req_valid &&  owner_q && mem_req_ready;
  assign m0_resp_valid = !owner_q && resp_valid;
  assign m1_resp_valid =  owner_q && resp_valid;
  assign m0_resp_err   = !owner_q && resp_err;
  assign m1_resp_err   =  owner_q && resp_err;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: two master drivers, a downstream responder,
// and a monitor holding a transaction-level round-robin model.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          gap;
    int          delay;
    int          bp;
    int          reqwait;
    bit          drop;
    bit          err;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        req_wen   [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wmask [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0] mem_resp_rdata;
  logic        busy;

  int          n_vec = 0;
  int          n_mis = 0;
  txn_t        txq0[$], txq1[$];
  resp_t       expq0[$], expq1[$];
  int          pl_delay [2], pl_bp [2], pl_reqwait [2];
  bit          pl_drop [2], pl_err [2];
  logic [31:0] pl_rdata [2];
  bit          mon_owner = 1'b0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .m0_req_valid(req_valid[0]), .m0_req_ready(req_ready[0]), .m0_req_addr(req_addr[0]),
    .m0_req_wen(req_wen[0]), .m0_req_wdata(req_wdata[0]), .m0_req_wmask(req_wmask[0]),
    .m0_resp_valid(resp_valid[0]), .m0_resp_ready(resp_ready[0]),
    .m0_resp_rdata(resp_rdata[0]), .m0_resp_err(resp_err[0]),
    .m1_req_valid(req_valid[1]), .m1_req_ready(req_ready[1]), .m1_req_addr(req_addr[1]),
    .m1_req_wen(req_wen[1]), .m1_req_wdata(req_wdata[1]), .m1_req_wmask(req_wmask[1]),
    .m1_resp_valid(resp_valid[1]), .m1_resp_ready(resp_ready[1]),
    .m1_resp_rdata(resp_rdata[1]), .m1_resp_err(resp_err[1]),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_vec++;
    n_mis++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic txn_t mk(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                              input logic [3:0] wmask, input int gap, input int delay, input int bp,
                              input int reqwait, input bit drop, input bit err,
                              input logic [31:0] rdata);
    txn_t t;
    t.addr = addr; t.wen = wen; t.wdata = wdata; t.wmask = wmask; t.gap = gap;
    t.delay = delay; t.bp = bp; t.reqwait = reqwait; t.drop = drop; t.err = err; t.rdata = rdata;
    return t;
  endfunction

  function automatic txn_t randTxn();
    return mk($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2),
              $urandom_range(0, 2), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              $urandom);
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_m0_req_ready"}, 64'(req_ready[0]), 64'd0);
    checkOutput({tag, "_m1_req_ready"}, 64'(req_ready[1]), 64'd0);
    checkOutput({tag, "_m0_resp_valid"}, 64'(resp_valid[0]), 64'd0);
    checkOutput({tag, "_m1_resp_valid"}, 64'(resp_valid[1]), 64'd0);
    checkOutput({tag, "_m0_resp_err"}, 64'(resp_err[0]), 64'd0);
    checkOutput({tag, "_m1_resp_err"}, 64'(resp_err[1]), 64'd0);
    checkOutput({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    checkOutput({tag, "_mem_resp_ready"}, 64'(mem_resp_ready), 64'd1);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // One master: present each queued transaction, wait for accept, then wait for its response.
  task automatic applyStimulus(input int m);
    txn_t  t;
    resp_t e;
    bit    ok;
    int    seen;
    while ((m == 0 ? txq0.size() : txq1.size()) > 0) begin
      t = (m == 0) ? txq0.pop_front() : txq1.pop_front();
      pl_delay[m] = t.delay; pl_bp[m] = t.bp; pl_reqwait[m] = t.reqwait;
      pl_drop[m] = t.drop; pl_err[m] = t.err; pl_rdata[m] = t.rdata;
      repeat (t.gap) begin @(posedge clock); #1; end
      req_addr[m] = t.addr; req_wen[m] = t.wen; req_wdata[m] = t.wdata; req_wmask[m] = t.wmask;
      req_valid[m] = 1'b1;
      resp_ready[m] = (t.bp == 0);
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clock);
        if (req_ready[m]) ok = 1'b1;
      end
      if (!ok) reportTimeout($sformatf("m%0d_req_accept", m));
      e.rdata = t.drop ? 32'h0 : t.rdata;
      e.err   = t.drop ? 1'b1 : t.err;
      if (ok) begin
        if (m == 0) expq0.push_back(e); else expq1.push_back(e);
      end
      @(posedge clock); #1;
      req_valid[m] = 1'b0;
      req_addr[m] = $urandom; req_wdata[m] = $urandom;
      ok = 1'b0;
      seen = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clock);
        if (resp_valid[m] && resp_ready[m]) ok = 1'b1;
        else if (resp_valid[m]) seen++;
        if (!ok && !resp_ready[m] && seen >= t.bp) begin
          @(posedge clock); #1;
          resp_ready[m] = 1'b1;
        end
      end
      if (!ok) reportTimeout($sformatf("m%0d_resp", m));
      @(posedge clock); #1;
      resp_ready[m] = 1'b0;
    end
  endtask

  // Downstream memory: accepts after reqwait REQ cycles, answers after delay cycles,
  // or for a dropped request answers far too late (a stale response the arbiter must sink).
  initial begin : responder
    int rp, wcnt, dcnt, d;
    bit drop, hsq, hsr, rv, rst, rerr;
    logic [31:0] rdat;
    rp = 0; wcnt = 0; dcnt = 0; d = 0; drop = 0; rerr = 0; rdat = 0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0; mem_resp_err = 1'b0;
    forever begin
      @(negedge clock);
      rst = reset;
      hsq = mem_req_valid && mem_req_ready;
      hsr = mem_resp_valid && mem_resp_ready;
      rv  = mem_req_valid;
      @(posedge clock); #1;
      if (rst) begin
        rp = 0; wcnt = 0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
      end else if (rp == 0) begin
        if (hsq) begin
          rp = 1; wcnt = 0; dcnt = 0;
          mem_req_ready = 1'b0;
          d = pl_delay[mon_owner]; drop = pl_drop[mon_owner];
          rdat = pl_rdata[mon_owner]; rerr = pl_err[mon_owner];
          if (!drop && d == 0) begin
            mem_resp_valid = 1'b1; mem_resp_rdata = rdat; mem_resp_err = rerr;
          end
        end else if (rv) begin
          wcnt++;
        end
      end else begin
        if (mem_resp_valid) begin
          if (drop || hsr) begin
            mem_resp_valid = 1'b0; mem_resp_rdata = $urandom; mem_resp_err = 1'b0;
            rp = 0; wcnt = 0;
          end
        end else begin
          dcnt++;
          if (!drop && dcnt == d) begin
            mem_resp_valid = 1'b1; mem_resp_rdata = rdat; mem_resp_err = rerr;
          end else if (drop && dcnt == 5) begin
            mem_resp_valid = 1'b1; mem_resp_rdata = $urandom; mem_resp_err = 1'($urandom_range(0, 1));
          end
        end
      end
      if (rp == 0 && !rst) mem_req_ready = (wcnt >= pl_reqwait[mon_owner]);
    end
  end

  // Monitor: transaction-level model (free -> grant from pending requests, round-robin on ties,
  // one cycle to forward, response or timeout error after 4 silent cycles) plus the scoreboard.
  initial begin : monitor
    int phase, rc;
    bit owner, last, seen;
    resp_t e;
    phase = 0; rc = 0; owner = 0; last = 1; seen = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        phase = 0; last = 1'b1;
        expq0.delete(); expq1.delete();
      end else begin
        case (phase)
          0: begin
            checkOutput("idle_busy", 64'(busy), 64'd0);
            checkOutput("idle_m0_req_ready", 64'(req_ready[0]), 64'd0);
            checkOutput("idle_m1_req_ready", 64'(req_ready[1]), 64'd0);
            checkOutput("idle_m0_resp_valid", 64'(resp_valid[0]), 64'd0);
            checkOutput("idle_m1_resp_valid", 64'(resp_valid[1]), 64'd0);
            checkOutput("idle_mem_req_valid", 64'(mem_req_valid), 64'd0);
            checkOutput("idle_mem_resp_ready", 64'(mem_resp_ready), 64'd1);
            if (req_valid[0] || req_valid[1]) begin
              owner = (req_valid[0] && req_valid[1]) ? !last : req_valid[1];
              mon_owner = owner;
              phase = 1;
            end
          end
          1: begin
            checkOutput("req_busy", 64'(busy), 64'd1);
            checkOutput("req_mem_req_valid", 64'(mem_req_valid), 64'd1);
            checkOutput("req_addr", 64'(mem_req_addr), 64'(req_addr[owner]));
            checkOutput("req_wen", 64'(mem_req_wen), 64'(req_wen[owner]));
            checkOutput("req_wdata", 64'(mem_req_wdata), 64'(req_wdata[owner]));
            checkOutput("req_wmask", 64'(mem_req_wmask), 64'(req_wmask[owner]));
            checkOutput("req_owner_ready", 64'(req_ready[owner]), 64'(mem_req_ready));
            checkOutput("req_other_ready", 64'(req_ready[!owner]), 64'd0);
            checkOutput("req_m0_resp_valid", 64'(resp_valid[0]), 64'd0);
            checkOutput("req_m1_resp_valid", 64'(resp_valid[1]), 64'd0);
            if (mem_req_ready) begin
              phase = 2; rc = 0; seen = 0;
            end
          end
          default: begin
            rc++;
            checkOutput("resp_busy", 64'(busy), 64'd1);
            checkOutput("resp_mem_req_valid", 64'(mem_req_valid), 64'd0);
            checkOutput("resp_m0_req_ready", 64'(req_ready[0]), 64'd0);
            checkOutput("resp_m1_req_ready", 64'(req_ready[1]), 64'd0);
            checkOutput("resp_other_valid", 64'(resp_valid[!owner]), 64'd0);
            if (resp_valid[owner] && !seen) begin
              seen = 1'b1;
              checkOutput("resp_latency", 64'(rc), pl_drop[owner] ? 64'd5 : 64'(pl_delay[owner] + 1));
            end
            if (mem_resp_valid)
              checkOutput("mem_resp_ready", 64'(mem_resp_ready),
                          pl_drop[owner] ? 64'd1 : 64'(resp_ready[owner]));
            if (resp_valid[owner] && resp_ready[owner]) begin
              if ((owner ? expq1.size() : expq0.size()) == 0) begin
                reportTimeout("unexpected_response");
              end else begin
                e = owner ? expq1.pop_front() : expq0.pop_front();
                checkOutput("resp_rdata_owner", 64'(resp_rdata[owner]), 64'(e.rdata));
                checkOutput("resp_rdata_other", 64'(resp_rdata[!owner]), 64'(e.rdata));
                checkOutput("resp_err_owner", 64'(resp_err[owner]), 64'(e.err));
                checkOutput("resp_err_other", 64'(resp_err[!owner]), 64'd0);
              end
              last = owner;
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bit ok;
    reset = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req_valid[m] = 1'b0; req_addr[m] = 32'h0; req_wen[m] = 1'b0;
      req_wdata[m] = 32'h0; req_wmask[m] = 4'h0; resp_ready[m] = 1'b0;
      pl_delay[m] = 0; pl_bp[m] = 0; pl_reqwait[m] = 0;
      pl_drop[m] = 1'b0; pl_err[m] = 1'b0; pl_rdata[m] = 32'h0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkResetOutputs("rst0");
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed openers: lone read, backpressured response, timeout, masked write with slow accept.
    txq0.push_back(mk(32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 0, 0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF));
    txq0.push_back(mk(32'h8000_0040, 1'b0, 32'h0, 4'h0, 0, 0, 2, 0, 1'b0, 1'b0, 32'hCAFE_F00D));
    txq0.push_back(mk(32'h8000_0080, 1'b0, 32'h0, 4'h0, 0, 0, 0, 0, 1'b1, 1'b0, 32'h1111_2222));
    txq1.push_back(mk(32'h8000_1000, 1'b1, 32'h1234_5678, 4'b0011, 14, 1, 0, 3, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < 4; i++) begin
      txq0.push_back(mk(32'h0000_1000 + 32'(i), 1'b0, 32'h0, 4'h0, 0, 0, 0, 0, 1'b0, 1'b0, 32'hA0 + 32'(i)));
      txq1.push_back(mk(32'h0000_2000 + 32'(i), 1'b0, 32'h0, 4'h0, 0, 0, 0, 0, 1'b0, 1'b0, 32'hB0 + 32'(i)));
    end
    for (int i = 0; i < 40; i++) begin
      txq0.push_back(randTxn());
      txq1.push_back(randTxn());
    end
    fork
      applyStimulus(0);
      applyStimulus(1);
    join
    repeat (10) begin @(posedge clock); #1; end

    // Abandon a transaction in its response phase with reset, then check the first tie.
    pl_drop[0] = 1'b1; pl_reqwait[0] = 0; pl_delay[0] = 0;
    req_addr[0] = 32'h8000_0100; req_wen[0] = 1'b0; req_valid[0] = 1'b1; resp_ready[0] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clock);
      if (req_ready[0]) ok = 1'b1;
    end
    if (!ok) reportTimeout("midrst_accept");
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    checkResetOutputs("rst_mid");
    txq0.push_back(mk(32'h0000_3000, 1'b0, 32'h0, 4'h0, 0, 1, 0, 0, 1'b0, 1'b0, 32'h5555_0000));
    txq1.push_back(mk(32'h0000_4000, 1'b1, 32'h7777_7777, 4'hF, 0, 0, 0, 1, 1'b0, 1'b1, 32'h6666_0000));
    @(posedge clock); #1;
    reset = 1'b0;
    fork
      applyStimulus(0);
      applyStimulus(1);
    join
    repeat (5) begin @(posedge clock); #1; end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
